// File: rtl/test_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : test_mailbox
// Purpose  : Watches M-stage stores for the tohost completion word and a
//            signature-push word. Provides a RUN-cycle watchdog and an optional
//            first-word-fall-through signature FIFO, enabled by the macro
//            TEST_MAILBOX_SIG_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module test_mailbox #(
    parameter logic [31:0] DONE_ADDR  = 32'h0000_0200,
    parameter logic [31:0] SIG_ADDR   = 32'h0000_0204,
    parameter int          MAX_CYCLES = 500,
    parameter int          SIG_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [30:0] exit_code,
    output logic [31:0] cycle_count,
    output logic        sig_valid,
    input  logic        sig_ready,
    output logic [31:0] sig_data,
    output logic        sig_overflow
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_PASS    = 2'd1,
        S_FAIL    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0] c_last_cycle = 32'(MAX_CYCLES - 1);

    state_t r_state;
    logic   w_run;
    logic   w_done_hit;

    assign w_run      = (r_state == S_RUN);
    assign w_done_hit = mem_write && (mem_addr == DONE_ADDR) && (mem_addr[1:0] == 2'b00);

    // A completion store outranks watchdog expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
            cycle_count <= '0;
        end else if (w_run) begin
            if (cycle_count != 32'hFFFF_FFFF) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (w_done_hit && mem_wdata[0]) begin
                done <= 1'b1;
                if (mem_wdata == 32'd1) begin
                    r_state   <= S_PASS;
                    pass      <= 1'b1;
                    exit_code <= '0;
                end else begin
                    r_state   <= S_FAIL;
                    exit_code <= mem_wdata[31:1];
                end
            end else if (cycle_count == c_last_cycle) begin
                r_state <= S_TIMEOUT;
                done    <= 1'b1;
                timeout <= 1'b1;
            end
        end
    end

`ifdef TEST_MAILBOX_SIG_FIFO_EN
    localparam int c_aw = $clog2(SIG_DEPTH);

    logic [31:0] r_mem [SIG_DEPTH];
    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    logic w_empty;
    logic w_full;
    logic w_sig_hit;
    logic w_push;
    logic w_pop;

    // Extra MSB on each pointer separates full from empty when indices match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_sig_hit = w_run && mem_write && (mem_addr == SIG_ADDR) && (mem_addr[1:0] == 2'b00);
    assign w_pop     = !w_empty && sig_ready;
    assign w_push    = w_sig_hit && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            sig_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_sig_hit && w_full && !w_pop) begin
                sig_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the head word is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= mem_wdata;
        end
    end

    assign sig_valid = !w_empty;
    assign sig_data  = w_empty ? 32'd0 : r_mem[r_rd_ptr[c_aw-1:0]];
`else
    logic w_unused;

    assign sig_valid    = 1'b0;
    assign sig_data     = 32'd0;
    assign sig_overflow = 1'b0;
    assign w_unused     = sig_ready ^ (SIG_ADDR == 32'd0) ^ (SIG_DEPTH == 0);
`endif

endmodule
`default_nettype wire

// File: doc/test_mailbox.md
TEST_MAILBOX -- requirements
Module: test_mailbox

Interface
REQ-001 Parameter DONE_ADDR, default 32'h0000_0200, byte address of the completion ("tohost") word.
REQ-002 Parameter SIG_ADDR, default 32'h0000_0204, byte address of the signature-push word.
REQ-003 Parameter MAX_CYCLES, default 500, watchdog limit in RUN cycles.
REQ-004 Parameter SIG_DEPTH, default 8, signature FIFO depth; power of two, at least 2.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 mem_write  in  1  data-memory store strobe, M stage.
REQ-008 mem_addr  in  32  store byte address (ALU result, M stage).
REQ-009 mem_wdata  in  32  store data, M stage.
REQ-010 done  out  1  test terminated (pass, fail or timeout).
REQ-011 pass  out  1  terminated with exit value 1.
REQ-012 timeout  out  1  watchdog expired before any completion store.
REQ-013 exit_code  out  31  mem_wdata[31:1] of the terminating store; 0 on pass or timeout.
REQ-014 cycle_count  out  32  RUN cycles elapsed, frozen at termination.
REQ-015 sig_valid  out  1  FIFO head valid.
REQ-016 sig_ready  in  1  consumer accepts the head.
REQ-017 sig_data  out  32  FIFO head word.
REQ-018 sig_overflow  out  1  sticky; a push was dropped because the FIFO was full.

Function
REQ-019 FSM states: RUN, PASS, FAIL, TIMEOUT; PASS, FAIL and TIMEOUT are terminal until reset.
REQ-020 Hit condition: mem_write=1, mem_addr equal to the parameter on all 32 bits, and mem_addr[1:0]=0; misaligned stores are ignored.
REQ-021 In RUN, a DONE hit with mem_wdata=1 moves to PASS; a DONE hit with mem_wdata[0]=1 and mem_wdata!=1 moves to FAIL; a DONE hit with mem_wdata[0]=0 is ignored.
REQ-022 Outputs done, pass, timeout and exit_code are registered and take their new values the cycle after the terminating store.
REQ-023 cycle_count increments by 1 every cycle in RUN, saturates at 32'hFFFF_FFFF, and holds in terminal states.
REQ-024 In RUN, when cycle_count = MAX_CYCLES-1 and there is no DONE hit that cycle, the FSM moves to TIMEOUT.
REQ-025 A DONE hit in the same cycle as watchdog expiry takes priority over timeout.
REQ-026 In terminal states all DONE and SIG hits are ignored; the FIFO continues to drain.
REQ-027 In RUN, a SIG hit pushes mem_wdata into the FIFO.
REQ-028 The FIFO is first-word fall-through: sig_data is valid in the same cycle sig_valid=1, and a pop occurs when sig_valid and sig_ready are both 1.
REQ-029 Push and pop in the same cycle are both performed, including when the FIFO is full; occupancy is unchanged.
REQ-030 A push to a full FIFO with no simultaneous pop is dropped and sets sig_overflow, which holds until reset.
REQ-031 FIFO read and write pointers wrap modulo SIG_DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
REQ-032 On reset: state=RUN; done=0, pass=0, timeout=0; exit_code=0; cycle_count=0; FIFO empty (sig_valid=0); sig_data=0; sig_overflow=0.
REQ-033 Reset asserted mid-test discards all state within one cycle; counting restarts at 0 on the first cycle after reset deasserts.

Configuration
REQ-034 With macro TEST_MAILBOX_SIG_FIFO_EN defined, the signature FIFO behaves per REQ-027..REQ-031.
REQ-035 Without TEST_MAILBOX_SIG_FIFO_EN: no FIFO storage is built; sig_valid=0, sig_data=0 and sig_overflow=0 constantly; SIG hits are ignored; all other behaviour is unchanged.

Verification
REQ-036 Reset release, store 32'h1 to 0x200 at RUN cycle 20 -> next cycle done=1, pass=1, exit_code=0, cycle_count=21 and held.
REQ-037 Store 32'h7 to 0x200 -> done=1, pass=0, exit_code=3; a later store of 32'h1 to 0x200 causes no change.
REQ-038 No stores -> timeout=1, done=1 with cycle_count=500; a store of 32'h1 at RUN cycle 499 instead gives pass=1, timeout=0.
REQ-039 Store 32'h4 to 0x200 and 32'h1 to 0x202 -> both ignored, done stays 0.
REQ-040 With the FIFO enabled and sig_ready=0, push 9 words 0..8 to 0x204 -> sig_overflow=1; then raising sig_ready pops 0..7 in order and sig_valid falls after 8 pops.
REQ-041 Full FIFO with sig_ready=1 and a SIG hit in the same cycle -> no overflow, occupancy stays 8, order is preserved.
